// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin, burst-locked arbiter sharing the single FIFO
//               write port among NUM_REQ requesters (write-clock domain).
//               Grants are gated by the FIFO full flag. A granted owner keeps
//               the port for up to MAX_BURST consecutive transfers. Transfer
//               latency is zero: grant, w_en and data_in are combinational
//               from registered state plus the current req/full.
// Ports       : w_clk, w_rst_n      - write clock, async active-low reset
//               req, req_data       - per-requester request and packed data
//               full                - FIFO full flag (blocks all grants)
//               write_error         - error pulse from the FIFO memory
//               gnt, w_en, data_in  - one-hot grant and memory write port
//               src_id              - index of current grantee (0 when none)
//               busy                - burst lock held
//               err_cnt, err_sticky - saturating error count / sticky flag
//                                     (only with FIFO_ARB_ERR_CNT_EN defined)
// Options     : `define FIFO_ARB_ERR_CNT_EN adds the error counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           w_clk,
    input  logic                           w_rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic                           full,
    input  logic                           write_error,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           w_en,
    output logic [DATA_SIZE-1:0]           data_in,
    output logic [$clog2(NUM_REQ)-1:0]     src_id,
    output logic                           busy
`ifdef FIFO_ARB_ERR_CNT_EN
    ,
    output logic [7:0]                     err_cnt,
    output logic                           err_sticky
`endif
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    // Lock state encoding (explicit width)
    localparam logic [0:0] c_ST_ARB  = 1'b0;
    localparam logic [0:0] c_ST_LOCK = 1'b1;

    logic [0:0]         r_lock,      w_lock_nxt;
    logic [c_ID_W-1:0]  r_owner,     w_owner_nxt;
    logic [c_CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
    logic [c_ID_W-1:0]  r_rr_ptr,    w_rr_ptr_nxt;

    logic               w_arb_found;
    logic [c_ID_W-1:0]  w_arb_idx;
    logic [c_ID_W-1:0]  w_cand_id;
    int                 w_cand;
    logic [c_ID_W-1:0]  w_sel_id;
    logic               w_owner_req;

    assign w_owner_req = req[r_owner];

    // Round-robin search: first set request at cyclic index after r_rr_ptr
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_cand      = 0;
        w_cand_id   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(r_rr_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_id = c_ID_W'(w_cand);
            if (!w_arb_found && req[w_cand_id]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lock      <= c_ST_ARB;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= c_ID_W'(NUM_REQ - 1);
        end else begin
            r_lock      <= w_lock_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_lock_nxt      = r_lock;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;
        case (r_lock)
            c_ST_LOCK: begin
                if (!w_owner_req) begin
                    // Owner gave up: release even while full, costs one bubble
                    w_lock_nxt   = c_ST_ARB;
                    w_rr_ptr_nxt = r_owner;
                end else if (!full) begin
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    if (r_burst_cnt == c_CNT_W'(MAX_BURST - 1)) begin
                        // Final transfer of the burst; re-arbitrate next cycle
                        w_lock_nxt   = c_ST_ARB;
                        w_rr_ptr_nxt = r_owner;
                    end
                end
            end
            default: begin
                if (!full && w_arb_found) begin
                    w_burst_cnt_nxt = c_CNT_W'(1);
                    if (MAX_BURST == 1) begin
                        w_rr_ptr_nxt = w_arb_idx;
                    end else begin
                        w_lock_nxt  = c_ST_LOCK;
                        w_owner_nxt = w_arb_idx;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (outputs forced idle while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        gnt      = '0;
        w_sel_id = '0;
        if (w_rst_n && !full) begin
            if (r_lock == c_ST_LOCK) begin
                if (w_owner_req) begin
                    gnt[r_owner] = 1'b1;
                    w_sel_id     = r_owner;
                end
            end else if (w_arb_found) begin
                gnt[w_arb_idx] = 1'b1;
                w_sel_id       = w_arb_idx;
            end
        end
    end

    assign src_id  = w_sel_id;
    assign w_en    = |(req & gnt);
    assign data_in = req_data[w_sel_id*DATA_SIZE +: DATA_SIZE];
    assign busy    = (r_lock == c_ST_LOCK);

`ifdef FIFO_ARB_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       r_err_sticky;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (write_error) begin
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_err_sticky <= 1'b1;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;
`else
    // write_error is intentionally ignored in this build
    logic w_unused;
    assign w_unused = write_error;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter
//               (NUM_REQ=4, DATA_SIZE=8, MAX_BURST=4). Inputs change 1 ns
//               after the rising edge; outputs are compared 2 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_SIZE = 8;
    localparam int MAX_BURST = 4;

    logic                         w_clk;
    logic                         w_rst_n;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic                         full;
    logic                         write_error;
    logic [NUM_REQ-1:0]           gnt;
    logic                         w_en;
    logic [DATA_SIZE-1:0]         data_in;
    logic [1:0]                   src_id;
    logic                         busy;
`ifdef FIFO_ARB_ERR_CNT_EN
    logic [7:0]                   err_cnt;
    logic                         err_sticky;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_SIZE (DATA_SIZE),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .req         (req),
        .req_data    (req_data),
        .full        (full),
        .write_error (write_error),
        .gnt         (gnt),
        .w_en        (w_en),
        .data_in     (data_in),
        .src_id      (src_id),
        .busy        (busy)
`ifdef FIFO_ARB_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt),
        .err_sticky  (err_sticky)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs may be changed on return
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Check one cycle's outputs for an expected one-hot grant, then clock
    task automatic exp_cycle(input string tag, input logic [3:0] eg, input logic eb);
        logic [1:0] eid;
        eid = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eg[i]) eid = 2'(i);
        end
        #2;
        check({tag, ".gnt"},    32'(gnt),    32'(eg));
        check({tag, ".w_en"},   32'(w_en),   32'(eg != 4'b0000));
        check({tag, ".src_id"}, 32'(src_id), 32'(eid));
        check({tag, ".busy"},   32'(busy),   32'(eb));
        if (eg != 4'b0000) begin
            check({tag, ".data"}, 32'(data_in), 32'(8'hA0 + 8'(eid)));
        end
        tick();
    endtask

    task automatic do_reset();
        w_rst_n = 1'b0;
        tick();
        w_rst_n = 1'b1;
    endtask

    initial begin
        int ids[17];
        w_rst_n     = 1'b0;
        req         = 4'b1111;
        req_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        full        = 1'b0;
        write_error = 1'b0;

        // Reset state with all requests pending: outputs must stay idle
        #2;
        check("rst.gnt",    32'(gnt),    32'd0);
        check("rst.w_en",   32'(w_en),   32'd0);
        check("rst.busy",   32'(busy),   32'd0);
        check("rst.src_id", 32'(src_id), 32'd0);
        tick();
        w_rst_n = 1'b1;

        // All four requesting: bursts of 4 in round-robin order, no bubbles
        ids = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        for (int c = 0; c < 17; c++) begin
            exp_cycle($sformatf("rr%0d", c), 4'(1 << ids[c]), (c % 4) != 0);
        end

        // Reset in the middle of requester 0's burst
        w_rst_n = 1'b0;
        #2;
        check("midrst.gnt",  32'(gnt),  32'd0);
        check("midrst.w_en", 32'(w_en), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        tick();
        w_rst_n = 1'b1;
        req = 4'b0110;
        exp_cycle("postrst", 4'b0010, 1'b0);

        // Idle: no requests, nothing granted
        do_reset();
        req = 4'b0000;
        exp_cycle("idle0", 4'b0000, 1'b0);
        exp_cycle("idle1", 4'b0000, 1'b0);

        // Requester 1 burst interrupted by full for 3 cycles
        req = 4'b0010;
        exp_cycle("full.t1", 4'b0010, 1'b0);
        exp_cycle("full.t2", 4'b0010, 1'b1);
        full = 1'b1;
        req  = 4'b0011;
        exp_cycle("full.s0", 4'b0000, 1'b1);
        exp_cycle("full.s1", 4'b0000, 1'b1);
        exp_cycle("full.s2", 4'b0000, 1'b1);
        full = 1'b0;
        exp_cycle("full.t3", 4'b0010, 1'b1);
        exp_cycle("full.t4", 4'b0010, 1'b1);
        exp_cycle("full.nx", 4'b0001, 1'b0);

        // Owner 0 drops its request after 2 transfers: one bubble, then req2
        do_reset();
        req = 4'b1101;
        exp_cycle("drop.t1", 4'b0001, 1'b0);
        exp_cycle("drop.t2", 4'b0001, 1'b1);
        req = 4'b1100;
        exp_cycle("drop.bub", 4'b0000, 1'b1);
        exp_cycle("drop.nx", 4'b0100, 1'b0);

        // Sole continuous requester 2 is re-granted with no idle cycle
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            exp_cycle($sformatf("solo%0d", c), 4'b0100, (c % 4) != 0);
        end

`ifdef FIFO_ARB_ERR_CNT_EN
        // Saturating error counter and sticky flag
        do_reset();
        req = 4'b0000;
        #2;
        check("err.init_cnt", 32'(err_cnt),    32'd0);
        check("err.init_stk", 32'(err_sticky), 32'd0);
        tick();
        write_error = 1'b1;
        for (int c = 0; c < 300; c++) tick();
        write_error = 1'b0;
        #2;
        check("err.cnt",    32'(err_cnt),    32'd255);
        check("err.sticky", 32'(err_sticky), 32'd1);
        w_rst_n = 1'b0;
        #2;
        check("err.rst_cnt", 32'(err_cnt),    32'd0);
        check("err.rst_stk", 32'(err_sticky), 32'd0);
        tick();
        w_rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
